// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: filters retired instructions into a FIFO with overflow
// policy, drop counting and a PC trigger that freezes capture after a window.
module retire_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int OVF_MODE  = 0,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     ret_valid_i,
  input  logic [XLEN-1:0]          ret_pc_i,
  input  logic [XLEN-1:0]          ret_instr_i,
  input  logic [4:0]               ret_rd_i,
  input  logic [XLEN-1:0]          ret_rd_data_i,
  input  logic                     ret_mem_wrt_i,
  input  logic [XLEN-1:0]          ret_mem_addr_i,
  input  logic [XLEN-1:0]          ret_mem_data_i,
  input  logic                     cfg_skip_nop_i,
  input  logic                     cfg_wr_only_i,
  input  logic                     trig_en_i,
  input  logic [XLEN-1:0]          trig_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_instr_o,
  output logic [XLEN-1:0]          out_rd_data_o,
  output logic [XLEN-1:0]          out_mem_addr_o,
  output logic [XLEN-1:0]          out_mem_data_o,
  output logic [4:0]               out_rd_o,
  output logic                     out_mem_wrt_o,
  output logic [15:0]              out_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [15:0]              drop_cnt_o,
  output logic [1:0]               state_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam bit OVW = (OVF_MODE != 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      rd;
    logic            mem_wrt;
    logic [15:0]     seq;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          entry_in;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     seq;
  logic [15:0]     drop_cnt;
  logic [PW-1:0]   post_cnt;
  state_t          state;
  state_t          state_nxt;

  logic is_nop;
  logic filt_ok;
  logic qual;
  logic trig_hit;
  logic is_full;
  logic is_empty;
  logic pop;
  logic do_write;
  logic do_drop;

  always_comb begin
    is_nop   = (ret_instr_i == '0) || (ret_instr_i == XLEN'(32'h13));
    filt_ok  = !(cfg_skip_nop_i && is_nop) &&
               !(cfg_wr_only_i && (ret_rd_i == '0) && !ret_mem_wrt_i);
    qual     = ret_valid_i && filt_ok && (state != ST_FROZEN);
    trig_hit = qual && trig_en_i && (ret_pc_i == trig_pc_i);
    is_full  = (count == DEPTH_C);
    is_empty = (count == '0);
    pop      = !is_empty && out_ready_i;
    // A qualified retire into a full buffer with no pop is always a drop; in
    // overwrite mode it still gets written and pushes the oldest entry out.
    do_drop  = qual && is_full && !pop;
    do_write = qual && (!is_full || pop || OVW);
  end

  always_comb begin
    entry_in          = '0;
    entry_in.pc       = ret_pc_i;
    entry_in.instr    = ret_instr_i;
    entry_in.rd_data  = ret_rd_data_i;
    entry_in.mem_addr = ret_mem_addr_i;
    entry_in.mem_data = ret_mem_data_i;
    entry_in.rd       = ret_rd_i;
    entry_in.mem_wrt  = ret_mem_wrt_i;
    entry_in.seq      = seq;
  end

  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (do_write && do_drop)) rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_drop && !pop) count <= count + 1'b1;
      else if (pop && !do_write) count <= count - 1'b1;
      if (qual) seq <= seq + 1'b1;
      if (do_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state    <= ST_RUN;
      post_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_RUN) && trig_hit && (POST_TRIG > 0)) post_cnt <= PW'(POST_TRIG);
      else if ((state == ST_POST) && qual) post_cnt <= post_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (trig_hit) state_nxt = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
      ST_POST:   if (qual && (post_cnt == PW'(1))) state_nxt = ST_FROZEN;
      ST_FROZEN: state_nxt = ST_FROZEN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    head           = mem[rd_ptr];
    out_valid_o    = !is_empty;
    out_pc_o       = head.pc;
    out_instr_o    = head.instr;
    out_rd_data_o  = head.rd_data;
    out_mem_addr_o = head.mem_addr;
    out_mem_data_o = head.mem_data;
    out_rd_o       = head.rd;
    out_mem_wrt_o  = head.mem_wrt;
    out_seq_o      = head.seq;
    count_o        = count;
    full_o         = is_full;
    empty_o        = is_empty;
    drop_cnt_o     = drop_cnt;
    state_o        = state;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: three configurations share one stimulus
// stream and are checked against a list-based behavioural model.
module tb_retire_trace_buffer;
  localparam int N = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        mem_wrt;
    logic [15:0] seq;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, ret_valid, ret_mem_wrt, skip_nop, wr_only, trig_en, out_ready;
  logic [31:0] ret_pc, ret_instr, ret_rd_data, ret_mem_addr, ret_mem_data, trig_pc;
  logic [4:0]  ret_rd;

  logic        o_valid [N];
  logic [31:0] o_pc [N], o_instr [N], o_rd_data [N], o_mem_addr [N], o_mem_data [N];
  logic [4:0]  o_rd [N];
  logic        o_mem_wrt [N], o_full [N], o_empty [N];
  logic [15:0] o_seq [N], o_drop [N];
  logic [1:0]  o_state [N];
  int          o_count [N];

  int depth [N] = '{4, 4, 16};
  int mode  [N] = '{0, 1, 0};
  int ptrig [N] = '{2, 0, 2};

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = (g == 2) ? 16 : 4;
    localparam int OM = (g == 1) ? 1 : 0;
    localparam int PT = (g == 1) ? 0 : 2;
    logic [$clog2(D):0] cnt;
    retire_trace_buffer #(.XLEN(32), .DEPTH(D), .OVF_MODE(OM), .POST_TRIG(PT)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
      .ret_rd_i(ret_rd), .ret_rd_data_i(ret_rd_data), .ret_mem_wrt_i(ret_mem_wrt),
      .ret_mem_addr_i(ret_mem_addr), .ret_mem_data_i(ret_mem_data),
      .cfg_skip_nop_i(skip_nop), .cfg_wr_only_i(wr_only),
      .trig_en_i(trig_en), .trig_pc_i(trig_pc),
      .out_valid_o(o_valid[g]), .out_ready_i(out_ready),
      .out_pc_o(o_pc[g]), .out_instr_o(o_instr[g]), .out_rd_data_o(o_rd_data[g]),
      .out_mem_addr_o(o_mem_addr[g]), .out_mem_data_o(o_mem_data[g]),
      .out_rd_o(o_rd[g]), .out_mem_wrt_o(o_mem_wrt[g]), .out_seq_o(o_seq[g]),
      .count_o(cnt), .full_o(o_full[g]), .empty_o(o_empty[g]),
      .drop_cnt_o(o_drop[g]), .state_o(o_state[g])
    );
    assign o_count[g] = int'(cnt);
  end

  // Model: each buffer is an ordered list, element 0 is the oldest entry.
  ent_t        mq [N][16];
  int          mcount [N];
  int unsigned mseq [N], mdrop [N];
  int          mstate [N], mpost [N];

  int checks = 0;
  int errors = 0;

  task automatic drop_head(input int i);
    for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
    mcount[i]--;
  endtask

  task automatic model_step();
    ent_t e;
    logic qual, pop, nop;
    for (int i = 0; i < N; i++) begin
      if (rst || clear) begin
        mcount[i] = 0; mseq[i] = 0; mdrop[i] = 0; mstate[i] = 0; mpost[i] = 0;
      end else begin
        pop  = (mcount[i] > 0) && out_ready;
        nop  = (ret_instr == 32'h0) || (ret_instr == 32'h13);
        qual = ret_valid && !(skip_nop && nop) && !(wr_only && ret_rd == 5'd0 && !ret_mem_wrt)
               && (mstate[i] != 2);
        e = '{pc: ret_pc, instr: ret_instr, rd_data: ret_rd_data, mem_addr: ret_mem_addr,
              mem_data: ret_mem_data, rd: ret_rd, mem_wrt: ret_mem_wrt, seq: 16'(mseq[i])};
        if (pop) drop_head(i);
        if (qual) begin
          if (mcount[i] < depth[i]) begin
            mq[i][mcount[i]] = e; mcount[i]++;
          end else begin
            if (mdrop[i] < 65535) mdrop[i]++;
            if (mode[i] == 1) begin
              drop_head(i); mq[i][mcount[i]] = e; mcount[i]++;
            end
          end
          mseq[i] = (mseq[i] + 1) % 65536;
          if (mstate[i] == 0 && trig_en && ret_pc == trig_pc) begin
            if (ptrig[i] == 0) mstate[i] = 2;
            else begin mstate[i] = 1; mpost[i] = ptrig[i]; end
          end else if (mstate[i] == 1) begin
            mpost[i]--;
            if (mpost[i] == 0) mstate[i] = 2;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic mw);
    ret_valid    = v;
    ret_pc       = pc;
    ret_instr    = instr;
    ret_rd       = rd;
    ret_mem_wrt  = mw;
    ret_rd_data  = $urandom;
    ret_mem_addr = $urandom;
    ret_mem_data = $urandom;
  endtask

  task automatic do_reset();
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    skip_nop = 0; wr_only = 0; trig_en = 0; trig_pc = 32'h0; out_ready = 0; clear = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    set_ret(1'b1, 32'h0, 32'h00100093, 5'd1, 1'b0);
    out_ready = 1; rst = 1; tick();
    rst = 0;
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0); out_ready = 0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_empty[i] !== 1'b1 || o_full[i] !== 1'b0 ||
          o_count[i] != 0 || o_drop[i] !== 16'd0 || o_state[i] !== 2'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got valid=%b empty=%b full=%b count=%0d drop=%0d state=%0d, expected 0 1 0 0 0 0",
                 i, o_valid[i], o_empty[i], o_full[i], o_count[i], o_drop[i], o_state[i]);
      end
    end
  endtask

  task automatic test_order();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_ret(1'b1, 32'(4 * k), 32'h00100093, 5'd1, 1'b0); tick();
    end
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_count[i] != 3) begin
        errors++; $display("FAIL order_count dut%0d: got %0d, expected 3", i, o_count[i]);
      end
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (o_valid[i] !== 1'b1 || o_pc[i] !== 32'(4 * k) || o_seq[i] !== 16'(k)) begin
          errors++;
          $display("FAIL order_pop dut%0d: got valid=%b pc=%h seq=%0d, expected 1 %h %0d",
                   i, o_valid[i], o_pc[i], o_seq[i], 32'(4 * k), k);
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_empty[i] !== 1'b1) begin
        errors++; $display("FAIL order_empty dut%0d: got %b, expected 1", i, o_empty[i]);
      end
    end
    // Push into an empty buffer while ready is held: visible only after the edge.
    set_ret(1'b1, 32'h200, 32'h00100093, 5'd2, 1'b0);
    checks++;
    if (o_valid[0] !== 1'b0) begin
      errors++; $display("FAIL no_bypass dut0: got valid=%b, expected 0", o_valid[0]);
    end
    tick();
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_valid[i] !== 1'b1 || o_count[i] != 1 || o_pc[i] !== 32'h200 || o_seq[i] !== 16'd3) begin
        errors++;
        $display("FAIL empty_push dut%0d: got valid=%b count=%0d pc=%h seq=%0d, expected 1 1 200 3",
                 i, o_valid[i], o_count[i], o_pc[i], o_seq[i]);
      end
    end
    tick(); out_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_ret(1'b1, 32'(4 * k), 32'h00100093, 5'd1, 1'b0); tick();
    end
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (o_count[0] != 4 || o_full[0] !== 1'b1 || o_pc[0] !== 32'h0 || o_seq[0] !== 16'd0 || o_drop[0] !== 16'd2) begin
      errors++;
      $display("FAIL ovf_drop_newest: got count=%0d full=%b pc=%h seq=%0d drop=%0d, expected 4 1 0 0 2",
               o_count[0], o_full[0], o_pc[0], o_seq[0], o_drop[0]);
    end
    checks++;
    if (o_count[1] != 4 || o_pc[1] !== 32'h8 || o_seq[1] !== 16'd2 || o_drop[1] !== 16'd2) begin
      errors++;
      $display("FAIL ovf_overwrite: got count=%0d pc=%h seq=%0d drop=%0d, expected 4 8 2 2",
               o_count[1], o_pc[1], o_seq[1], o_drop[1]);
    end
    checks++;
    if (o_count[2] != 6 || o_drop[2] !== 16'd0) begin
      errors++; $display("FAIL ovf_deep: got count=%0d drop=%0d, expected 6 0", o_count[2], o_drop[2]);
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_pc[0] !== 32'(4 * k) || o_pc[1] !== 32'(8 + 4 * k)) begin
        errors++;
        $display("FAIL ovf_drain: got pc0=%h pc1=%h, expected %h %h", o_pc[0], o_pc[1], 32'(4 * k), 32'(8 + 4 * k));
      end
      tick();
    end
    out_ready = 0;
    set_ret(1'b1, 32'h100, 32'h00100093, 5'd1, 1'b0); tick();
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_count[i] != 1 || o_seq[i] !== 16'd6) begin
        errors++; $display("FAIL ovf_next_seq dut%0d: got count=%0d seq=%0d, expected 1 6", i, o_count[i], o_seq[i]);
      end
    end
  endtask

  task automatic test_filters();
    logic [31:0] ins [3] = '{32'h13, 32'h00500093, 32'h0};
    do_reset();
    skip_nop = 1;
    for (int k = 0; k < 3; k++) begin
      set_ret(1'b1, 32'(4 * k), ins[k], 5'd1, 1'b0); tick();
    end
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_count[i] != 1 || o_seq[i] !== 16'd0 || o_instr[i] !== 32'h00500093) begin
        errors++;
        $display("FAIL skip_nop dut%0d: got count=%0d seq=%0d instr=%h, expected 1 0 00500093",
                 i, o_count[i], o_seq[i], o_instr[i]);
      end
    end
    skip_nop = 0; wr_only = 1;
    set_ret(1'b1, 32'h40, 32'h00000033, 5'd0, 1'b0); tick();
    set_ret(1'b1, 32'h44, 32'h00112023, 5'd0, 1'b1); tick();
    set_ret(1'b1, 32'h48, 32'h00300193, 5'd3, 1'b0); tick();
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_count[i] != mcount[i] || o_drop[i] !== 16'(mdrop[i])) begin
        errors++;
        $display("FAIL wr_only dut%0d: got count=%0d drop=%0d, expected %0d %0d",
                 i, o_count[i], o_drop[i], mcount[i], mdrop[i]);
      end
    end
    wr_only = 0;
  endtask

  task automatic test_trigger();
    logic [1:0] st_exp;
    do_reset();
    trig_en = 1; trig_pc = 32'h10;
    for (int k = 0; k < 9; k++) begin
      set_ret(1'b1, 32'(4 * k), 32'h00100093, 5'd1, 1'b0); tick();
    end
    trig_en = 0;
    for (int k = 0; k < 3; k++) begin
      set_ret(1'b1, 32'h300, 32'h00100093, 5'd1, 1'b0); tick();
    end
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (o_count[2] != 7 || o_state[2] !== 2'd2 || o_drop[2] !== 16'd0) begin
      errors++;
      $display("FAIL trig_window: got count=%0d state=%0d drop=%0d, expected 7 2 0", o_count[2], o_state[2], o_drop[2]);
    end
    checks++;
    if (o_state[0] !== 2'd2 || o_drop[0] !== 16'd3 || o_count[0] != 4) begin
      errors++;
      $display("FAIL trig_full_drop: got state=%0d drop=%0d count=%0d, expected 2 3 4", o_state[0], o_drop[0], o_count[0]);
    end
    checks++;
    if (o_state[1] !== 2'd2 || o_drop[1] !== 16'd1 || o_pc[1] !== 32'h4) begin
      errors++;
      $display("FAIL trig_zero_post: got state=%0d drop=%0d pc=%h, expected 2 1 4", o_state[1], o_drop[1], o_pc[1]);
    end
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (o_valid[2] !== 1'b1 || o_pc[2] !== 32'(4 * k)) begin
        errors++; $display("FAIL trig_drain: got valid=%b pc=%h, expected 1 %h", o_valid[2], o_pc[2], 32'(4 * k));
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_valid[i] !== (mcount[i] > 0) || (mcount[i] > 0 && o_pc[i] !== mq[i][0].pc)) begin
          errors++;
          $display("FAIL trig_drain_small dut%0d: got valid=%b pc=%h, expected %b %h",
                   i, o_valid[i], o_pc[i], mcount[i] > 0, mq[i][0].pc);
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_empty[i] !== 1'b1 || o_state[i] !== 2'd2) begin
        errors++; $display("FAIL trig_hold dut%0d: got empty=%b state=%0d, expected 1 2", i, o_empty[i], o_state[i]);
      end
    end
    clear = 1; tick(); clear = 0;
    st_exp = 2'd0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_state[i] !== st_exp || o_count[i] != 0) begin
        errors++; $display("FAIL clear dut%0d: got state=%0d count=%0d, expected 0 0", i, o_state[i], o_count[i]);
      end
    end
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_ret(1'b1, 32'(4 * k), 32'h00100093, 5'd1, 1'b0); tick();
    end
    out_ready = 1;
    for (int k = 4; k < 7; k++) begin
      set_ret(1'b1, 32'(4 * k), 32'h00100093, 5'd1, 1'b0); tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_count[i] != 4 || o_drop[i] !== 16'd0 || o_pc[i] !== 32'(4 * (k - 3))) begin
          errors++;
          $display("FAIL full_pop_push dut%0d: got count=%0d drop=%0d pc=%h, expected 4 0 %h",
                   i, o_count[i], o_drop[i], o_pc[i], 32'(4 * (k - 3)));
        end
      end
    end
    rst = 1; tick(); rst = 0;
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0); out_ready = 0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (o_count[i] != 0 || o_state[i] !== 2'd0 || o_drop[i] !== 16'd0) begin
        errors++;
        $display("FAIL rst_midstream dut%0d: got count=%0d state=%0d drop=%0d, expected 0 0 0",
                 i, o_count[i], o_state[i], o_drop[i]);
      end
    end
  endtask

  task automatic test_random();
    ent_t act;
    logic [31:0] ins;
    do_reset();
    trig_pc = 32'h40;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: ins = 32'h0;
        1: ins = 32'h13;
        default: ins = $urandom;
      endcase
      set_ret($urandom_range(0, 9) < 7, 32'($urandom_range(0, 31) * 4), ins,
              ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
      out_ready = $urandom_range(0, 9) < 4;
      if ($urandom_range(0, 49) == 0) skip_nop = 1'($urandom);
      if ($urandom_range(0, 49) == 0) wr_only = 1'($urandom);
      trig_en = $urandom_range(0, 7) == 0;
      clear   = $urandom_range(0, 79) == 0;
      rst     = $urandom_range(0, 499) == 0;
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (o_count[i] != mcount[i] || o_valid[i] !== (mcount[i] > 0) ||
            o_full[i] !== (mcount[i] == depth[i]) || o_empty[i] !== (mcount[i] == 0) ||
            o_drop[i] !== 16'(mdrop[i]) || o_state[i] !== 2'(mstate[i])) begin
          errors++;
          $display("FAIL rand_status dut%0d cyc%0d: got count=%0d drop=%0d state=%0d, expected %0d %0d %0d",
                   i, c, o_count[i], o_drop[i], o_state[i], mcount[i], mdrop[i], mstate[i]);
        end
        if (mcount[i] > 0) begin
          act = '{pc: o_pc[i], instr: o_instr[i], rd_data: o_rd_data[i], mem_addr: o_mem_addr[i],
                  mem_data: o_mem_data[i], rd: o_rd[i], mem_wrt: o_mem_wrt[i], seq: o_seq[i]};
          checks++;
          if (act !== mq[i][0]) begin
            errors++;
            $display("FAIL rand_head dut%0d cyc%0d: got %h, expected %h", i, c, act, mq[i][0]);
          end
        end
      end
    end
    rst = 0; clear = 0;
  endtask

  initial begin
    rst = 1; clear = 0; skip_nop = 0; wr_only = 0; trig_en = 0; trig_pc = 32'h0; out_ready = 0;
    set_ret(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    test_reset();
    test_order();
    test_overflow();
    test_filters();
    test_trigger();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 Parameters, one per line:
- XLEN, 32, datapath width.
- DEPTH, 16, entry count; power of two, >= 2.
- OVF_MODE, 0, 0 = drop newest when full, 1 = overwrite oldest.
- POST_TRIG, 8, qualified retires captured after the trigger before freezing.
REQ-002 Ports, one per line:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- ret_valid_i  in  1  retire strobe from the pipeline.
- ret_pc_i  in  XLEN  retired PC.
- ret_instr_i  in  XLEN  retired instruction.
- ret_rd_i  in  5  destination register.
- ret_rd_data_i  in  XLEN  writeback data.
- ret_mem_wrt_i  in  1  store flag.
- ret_mem_addr_i  in  XLEN  store address.
- ret_mem_data_i  in  XLEN  store data.
- cfg_skip_nop_i  in  1  discard retires whose instr is 0x00000000 or 0x00000013.
- cfg_wr_only_i  in  1  keep only retires with (rd != 0) or mem_wrt = 1.
- trig_en_i  in  1  arm PC trigger.
- trig_pc_i  in  XLEN  trigger PC.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  consumer accepts the head.
- out_pc_o, out_instr_o, out_rd_data_o, out_mem_addr_o, out_mem_data_o  out  XLEN  head fields.
- out_rd_o  out  5  head rd.
- out_mem_wrt_o  out  1  head store flag.
- out_seq_o  out  16  head sequence number.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- drop_cnt_o  out  16  lost-entry counter; saturates at 0xFFFF.
- state_o  out  2  trigger state: 0 RUN, 1 POST, 2 FROZEN.

Function
REQ-003 A retire is qualified when ret_valid_i = 1, it passes both enabled filters, and state != FROZEN.
REQ-004 Each qualified retire takes the current seq value, whether it is stored or dropped; seq then increments mod 2^16.
REQ-005 Pop occurs when out_valid_o = 1 and out_ready_i = 1; the head advances at that edge.
REQ-006 out_valid_o = !empty_o; out_* fields combinationally reflect the head entry.
REQ-007 Latency: a retire qualified at edge N is visible at the head no earlier than after edge N; there is no same-cycle bypass.
REQ-008 Full with a simultaneous pop: the push is accepted and count is unchanged. This holds in both modes; no drop occurs.
REQ-009 OVF_MODE = 0, full, no pop: the new entry is discarded and drop_cnt_o increments.
REQ-010 OVF_MODE = 1, full, no pop: the oldest entry is discarded, the new entry is written, and drop_cnt_o increments.
REQ-011 In OVF_MODE = 1 only, head fields may change while out_valid_o = 1 and out_ready_i = 0. out_seq_o exposes the gap.
REQ-012 Empty with a simultaneous push: out_valid_o rises the next cycle. There is no pop on empty.
REQ-013 Pointers wrap modulo DEPTH. count_o is tracked independently of the pointers, so full and empty are unambiguous.
REQ-014 FSM transitions:
- RUN -> POST on a qualified retire with trig_en_i = 1 and ret_pc_i == trig_pc_i; that retire is stored and the post counter loads POST_TRIG.
- POST: each qualified retire decrements the counter. At 0, -> FROZEN on the same edge the last entry is stored.
- POST_TRIG = 0: RUN -> FROZEN directly on the trigger retire.
- FROZEN: no pushes; pops continue; the state holds until rst_i or clear_i.
- trig_en_i deassertion has no effect once the state has left RUN.
REQ-015 Drops are counted only for qualified retires. Filtered and frozen retires do not count.

Reset
REQ-016 On rst_i or clear_i, at the next edge:
- pointers, count, seq, drop_cnt and post counter go to 0;
- state goes to RUN;
- out_valid_o = 0, empty_o = 1, full_o = 0;
- storage contents are don't-care.
REQ-017 Reset or clear takes priority over any simultaneous push or pop; the entries involved are lost and not counted.

Verification
REQ-018 Benches SHALL cover these directed scenarios:
- DEPTH=4, 3 retires with PC 0x0, 0x4, 0x8 and out_ready_i = 0 -> count_o = 3; then ready = 1 -> PCs pop in order with seq 0, 1, 2, and empty_o = 1 after.
- OVF_MODE=0, DEPTH=4, 6 retires, no pop -> PCs 0x0-0xC retained, drop_cnt_o = 2, next seq = 6.
- OVF_MODE=1, same stimulus -> head PC = 0x8, out_seq_o = 2, drop_cnt_o = 2.
- cfg_skip_nop_i = 1, retire instrs 0x13, 0x00500093, 0x0 -> one entry, seq 0, instr 0x00500093.
- POST_TRIG=2, trig_pc_i = 0x10, retires PC 0x0..0x20 step 4 -> entries 0x0..0x18, state_o = 2, no further pushes, pops still drain.
- Full FIFO, pop and push together -> count_o unchanged, drop_cnt_o unchanged; rst_i mid-stream -> count_o = 0 and state_o = 0 the next cycle.
